// File: rtl/store_formatter_if.sv
// ---------------------------------------------------------------------------
// store_formatter_if
// Data-memory write port seen by the store formatter.
//   data_address      word-aligned byte address of the write
//   data_write        write strobe, held until the bus accepts it
//   data_writedata    byte-lane-steered store data
//   data_byteenable   active byte lanes (bit k <-> writedata[8k+7:8k])
//   data_waitrequest  bus not ready; the write is held while high
// master: the formatter (drives the write); slave: the memory/bus side.
// ---------------------------------------------------------------------------
interface store_formatter_if;
    logic [31:0] data_address;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic        data_waitrequest;

    modport master (
        output data_address,
        output data_write,
        output data_writedata,
        output data_byteenable,
        input  data_waitrequest
    );

    modport slave (
        input  data_address,
        input  data_write,
        input  data_writedata,
        input  data_byteenable,
        output data_waitrequest
    );
endinterface

// File: rtl/store_formatter.sv
// ---------------------------------------------------------------------------
// store_formatter
// Memory-stage store formatter for MIPS SB/SH/SW/SWL/SWR. Converts the
// effective address and rt value into a word-aligned, little-endian
// byte-enabled bus write and holds the write until the bus accepts it,
// stalling the pipeline meanwhile.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   op_memory           opcode of the memory-stage instruction
//   store_req_memory    memory stage holds a store (sampled only in IDLE)
//   address_memory      effective byte address
//   src_B_memory        rt value to be stored
//   busy_memory         high while a write is outstanding
//   done_memory         1-cycle pulse: write accepted
//   addr_error_memory   1-cycle pulse: misaligned or non-store request
//   timeout_memory      1-cycle pulse: write abandoned after MAX_WAIT waits
//   bus                 data-memory write port (master side)
// ---------------------------------------------------------------------------
module store_formatter #(
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op_memory,
    input  logic                store_req_memory,
    input  logic [31:0]         address_memory,
    input  logic [31:0]         src_B_memory,
    output logic                busy_memory,
    output logic                done_memory,
    output logic                addr_error_memory,
    output logic                timeout_memory,
    store_formatter_if.master   bus
);

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWR = 6'b101110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    // The counter holds the number of wait edges already seen; the edge that
    // would make it reach MAX_WAIT is the one that abandons the write.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    // ------------------------------------------------------------------
    // Combinational formatting of the current request
    // ------------------------------------------------------------------
    logic [1:0]  offset;
    logic [1:0]  swl_shift;
    logic        fmt_valid;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_raw;
    logic [31:0] fmt_wd;

    assign offset    = address_memory[1:0];
    // SWL moves the top (o+1) bytes of rt down into the low lanes.
    assign swl_shift = 2'd3 - offset;

    always_comb begin
        fmt_valid = 1'b0;
        fmt_be    = 4'b0000;
        fmt_raw   = 32'h0;
        case (op_memory)
            OP_SB: begin
                fmt_valid = 1'b1;
                fmt_be    = 4'b0001 << offset;
                fmt_raw   = {24'h0, src_B_memory[7:0]} << {offset, 3'b000};
            end
            OP_SH: begin
                fmt_valid = ~offset[0];
                fmt_be    = 4'b0011 << offset;
                fmt_raw   = {16'h0, src_B_memory[15:0]} << {offset, 3'b000};
            end
            OP_SW: begin
                fmt_valid = (offset == 2'd0);
                fmt_be    = 4'b1111;
                fmt_raw   = src_B_memory;
            end
            OP_SWL: begin
                fmt_valid = 1'b1;
                fmt_be    = 4'b1111 >> swl_shift;
                fmt_raw   = src_B_memory >> {swl_shift, 3'b000};
            end
            OP_SWR: begin
                fmt_valid = 1'b1;
                fmt_be    = 4'b1111 << offset;
                fmt_raw   = src_B_memory << {offset, 3'b000};
            end
            default: begin
                fmt_valid = 1'b0;
            end
        endcase
    end

    // Lanes that are not enabled are forced to zero on the bus.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign fmt_wd[8*gi +: 8] = fmt_be[gi] ? fmt_raw[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write handshake FSM
    // ------------------------------------------------------------------
    logic [0:0]       state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [31:0]      address_reg;
    logic [31:0]      writedata_reg;
    logic [3:0]       byteenable_reg;
    logic             write_reg;
    logic             done_reg;
    logic             error_reg;
    logic             timeout_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            address_reg    <= 32'h0;
            writedata_reg  <= 32'h0;
            byteenable_reg <= 4'h0;
            write_reg      <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (store_req_memory) begin
                        if (fmt_valid) begin
                            address_reg    <= {address_memory[31:2], 2'b00};
                            writedata_reg  <= fmt_wd;
                            byteenable_reg <= fmt_be;
                            write_reg      <= 1'b1;
                            wait_cnt_reg   <= '0;
                            state_reg      <= ST_BUSY;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    // Address/data/byteenable stay frozen for the whole write.
                    if (!bus.data_waitrequest) begin
                        write_reg <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (wait_cnt_reg == CNT_LAST) begin
                        write_reg    <= 1'b0;
                        timeout_reg  <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_memory         = (state_reg == ST_BUSY);
    assign done_memory         = done_reg;
    assign addr_error_memory   = error_reg;
    assign timeout_memory      = timeout_reg;
    assign bus.data_address    = address_reg;
    assign bus.data_write      = write_reg;
    assign bus.data_writedata  = writedata_reg;
    assign bus.data_byteenable = byteenable_reg;

endmodule

// File: tb/tb_store_formatter.sv
// ---------------------------------------------------------------------------
// tb_store_formatter
// Table-driven bench for store_formatter (MAX_WAIT = 4). Each store record
// pushes its expected outcome onto a queue; a monitor pops it when the DUT
// reports done/error/timeout and compares the captured bus write.
// ---------------------------------------------------------------------------
module tb_store_formatter;

    localparam int MAXW = 4;

    localparam logic [5:0] T_SB  = 6'b101000;
    localparam logic [5:0] T_SH  = 6'b101001;
    localparam logic [5:0] T_SWL = 6'b101010;
    localparam logic [5:0] T_SW  = 6'b101011;
    localparam logic [5:0] T_SWR = 6'b101110;
    localparam logic [5:0] T_LW  = 6'b100011;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_TO   = 2;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        int          nwait;
        int          kind;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op_memory = 6'h0;
    logic        store_req_memory = 1'b0;
    logic [31:0] address_memory = 32'h0;
    logic [31:0] src_B_memory = 32'h0;
    logic        busy_memory;
    logic        done_memory;
    logic        addr_error_memory;
    logic        timeout_memory;

    store_formatter_if bus_if ();

    store_formatter #(.MAX_WAIT(MAXW)) dut (
        .clk               (clk),
        .reset             (reset),
        .op_memory         (op_memory),
        .store_req_memory  (store_req_memory),
        .address_memory    (address_memory),
        .src_B_memory      (src_B_memory),
        .busy_memory       (busy_memory),
        .done_memory       (done_memory),
        .addr_error_memory (addr_error_memory),
        .timeout_memory    (timeout_memory),
        .bus               (bus_if.master)
    );

    always #5 clk = ~clk;

    int   vec_count = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
            miscompares++;
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] rt, input int nwait, input int kind,
                                input logic [31:0] ea, input logic [3:0] be,
                                input logic [31:0] wd, input int cyc);
        vec_t v;
        v.op = op; v.addr = addr; v.rt = rt; v.nwait = nwait; v.kind = kind;
        v.exp_addr = ea; v.exp_be = be; v.exp_wd = wd; v.exp_cycles = cyc;
        return v;
    endfunction

    // Monitor: captures each bus write and checks it when the outcome pulses.
    initial begin : monitor
        int          wc;
        logic [31:0] cap_addr;
        logic [31:0] cap_wd;
        logic [3:0]  cap_be;
        int          npulse;
        int          kact;
        exp_t        e;
        wc = 0; cap_addr = 0; cap_wd = 0; cap_be = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wc = 0;
            end else begin
                if (bus_if.data_write) begin
                    if (wc == 0) begin
                        cap_addr = bus_if.data_address;
                        cap_wd   = bus_if.data_writedata;
                        cap_be   = bus_if.data_byteenable;
                    end else begin
                        chk("hold_addr", bus_if.data_address, cap_addr);
                        chk("hold_wd", bus_if.data_writedata, cap_wd);
                        chk("hold_be", {28'h0, bus_if.data_byteenable}, {28'h0, cap_be});
                    end
                    wc++;
                end
                chk("busy_vs_write", {31'h0, busy_memory}, {31'h0, bus_if.data_write});
                npulse = int'(done_memory) + int'(addr_error_memory) + int'(timeout_memory);
                if (npulse > 1) begin
                    $display("FAIL pulse_exclusive: got %0d pulses expected 1", npulse);
                    miscompares++;
                end
                if (npulse != 0) begin
                    kact = done_memory ? K_DONE : (addr_error_memory ? K_ERR : K_TO);
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_pulse: got kind %0d expected none", kact);
                        miscompares++;
                    end else begin
                        e = exp_q.pop_front();
                        chk("kind", kact, e.kind);
                        chk("write_cycles", wc, e.cycles);
                        if (e.kind != K_ERR) begin
                            chk("addr", cap_addr, e.addr);
                            chk("be", {28'h0, cap_be}, {28'h0, e.be});
                            chk("wd", cap_wd, e.wd);
                        end
                        $display("outcome kind=%0d addr=%h be=%b wd=%h cycles=%0d",
                                 kact, cap_addr, cap_be, cap_wd, wc);
                    end
                    wc = 0;
                end
            end
        end
    end

    task automatic do_store(input vec_t v);
        exp_t e;
        @(negedge clk);
        op_memory        = v.op;
        address_memory   = v.addr;
        src_B_memory     = v.rt;
        store_req_memory = 1'b1;
        bus_if.data_waitrequest = (v.nwait > 0);
        e.kind = v.kind; e.addr = v.exp_addr; e.be = v.exp_be;
        e.wd = v.exp_wd; e.cycles = v.exp_cycles;
        exp_q.push_back(e);
        vec_count++;
        $display("store op=%b addr=%h rt=%h nwait=%0d kind=%0d", v.op, v.addr, v.rt, v.nwait, v.kind);
        @(posedge clk);
        #1 store_req_memory = 1'b0;
        if (v.kind != K_ERR) begin
            for (int i = 0; i < v.nwait; i++) begin
                @(posedge clk);
                #1;
                if (i == v.nwait - 1) bus_if.data_waitrequest = 1'b0;
            end
            if (v.kind == K_DONE) @(posedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t vecs[16];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        vecs[0]  = mk(T_SB,  32'h1003, 32'hAABBCCDD, 0, K_DONE, 32'h1000, 4'b1000, 32'hDD000000, 1);
        vecs[1]  = mk(T_SH,  32'h2002, 32'h00001234, 0, K_DONE, 32'h2000, 4'b1100, 32'h12340000, 1);
        vecs[2]  = mk(T_SH,  32'h2001, 32'h00001234, 0, K_ERR,  32'h0,    4'b0000, 32'h0,        0);
        vecs[3]  = mk(T_SWL, 32'h3001, 32'h11223344, 0, K_DONE, 32'h3000, 4'b0011, 32'h00001122, 1);
        vecs[4]  = mk(T_SWR, 32'h3001, 32'h11223344, 0, K_DONE, 32'h3000, 4'b1110, 32'h22334400, 1);
        vecs[5]  = mk(T_SW,  32'h4000, 32'hCAFEF00D, 3, K_DONE, 32'h4000, 4'b1111, 32'hCAFEF00D, 4);
        vecs[6]  = mk(T_SW,  32'h4000, 32'h0BADBEEF, MAXW, K_TO, 32'h4000, 4'b1111, 32'h0BADBEEF, MAXW);
        vecs[7]  = mk(T_SB,  32'h5000, 32'h12345678, 0, K_DONE, 32'h5000, 4'b0001, 32'h00000078, 1);
        vecs[8]  = mk(T_SB,  32'h5001, 32'h12345678, 0, K_DONE, 32'h5000, 4'b0010, 32'h00007800, 1);
        vecs[9]  = mk(T_SW,  32'h4002, 32'h12345678, 0, K_ERR,  32'h0,    4'b0000, 32'h0,        0);
        vecs[10] = mk(T_LW,  32'h4000, 32'h12345678, 0, K_ERR,  32'h0,    4'b0000, 32'h0,        0);
        vecs[11] = mk(T_SWL, 32'h3003, 32'h11223344, 0, K_DONE, 32'h3000, 4'b1111, 32'h11223344, 1);
        vecs[12] = mk(T_SWL, 32'h3000, 32'h11223344, 0, K_DONE, 32'h3000, 4'b0001, 32'h00000011, 1);
        vecs[13] = mk(T_SWR, 32'h3003, 32'h11223344, 0, K_DONE, 32'h3000, 4'b1000, 32'h44000000, 1);
        vecs[14] = mk(T_SH,  32'h2000, 32'hFFFF1234, 0, K_DONE, 32'h2000, 4'b0011, 32'h00001234, 1);
        vecs[15] = mk(T_SB,  32'h1002, 32'hAABBCCDD, 1, K_DONE, 32'h1000, 4'b0100, 32'h00DD0000, 2);

        bus_if.data_waitrequest = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec_count++;
        chk("rst_addr", bus_if.data_address, 32'h0);
        chk("rst_wd", bus_if.data_writedata, 32'h0);
        chk("rst_be", {28'h0, bus_if.data_byteenable}, 32'h0);
        chk("rst_write", {31'h0, bus_if.data_write}, 32'h0);
        chk("rst_busy", {31'h0, busy_memory}, 32'h0);
        $display("reset check done");
        reset = 1'b0;

        foreach (vecs[i]) do_store(vecs[i]);

        // Reset while a write is stalled: everything clears, no outcome pulse.
        @(negedge clk);
        op_memory = T_SW; address_memory = 32'h6000; src_B_memory = 32'h55AA55AA;
        store_req_memory = 1'b1;
        bus_if.data_waitrequest = 1'b1;
        vec_count++;
        @(posedge clk);
        #1 store_req_memory = 1'b0;
        chk("mid_write", {31'h0, bus_if.data_write}, 32'h1);
        chk("mid_busy", {31'h0, busy_memory}, 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rb_write", {31'h0, bus_if.data_write}, 32'h0);
        chk("rb_busy", {31'h0, busy_memory}, 32'h0);
        chk("rb_addr", bus_if.data_address, 32'h0);
        chk("rb_wd", bus_if.data_writedata, 32'h0);
        chk("rb_be", {28'h0, bus_if.data_byteenable}, 32'h0);
        chk("rb_pulses", {29'h0, done_memory, addr_error_memory, timeout_memory}, 32'h0);
        $display("reset during busy: write=%b busy=%b", bus_if.data_write, busy_memory);
        @(posedge clk);
        #1 reset = 1'b0;
        bus_if.data_waitrequest = 1'b0;
        repeat (3) @(negedge clk);

        do_store(mk(T_SW, 32'h7000, 32'h01020304, 2, K_DONE, 32'h7000, 4'b1111, 32'h01020304, 3));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
